// File: rtl/data_mem_dump_reader_if.sv
// Bus bundle between the dump reader, the data memory read port and the UART TX.
interface data_mem_dump_reader_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;

    // Reader side: drives the memory read strobe and the TX request.
    modport master (
        output mem_addr, mem_rd_en, tx_data, tx_start,
        input  mem_rdata, tx_done
    );

    // Memory / UART side: answers with read data and the byte-sent pulse.
    modport slave (
        input  mem_addr, mem_rd_en, tx_data, tx_start,
        output mem_rdata, tx_done
    );
endinterface

// File: rtl/data_mem_dump_reader.sv
// Debug-side data memory dump: reads DEPTH words in order and sends each one
// to the UART transmitter as four bytes, most significant byte first.
// Only meant to run while the pipeline is halted.
module data_mem_dump_reader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    data_mem_dump_reader_if.master bus
);
    localparam int unsigned      WI_W      = $clog2(DEPTH) + 1;
    localparam logic [WI_W-1:0]  LAST_WORD = WI_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        LOAD,
        SEND,
        WAIT_TX,
        FIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WI_W-1:0] word_index;
    logic [WI_W-1:0] word_index_next;
    logic [1:0]      byte_index;
    logic [31:0]     shreg;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next word index; tx_done only counts in WAIT_TX.
    always_comb begin
        state_next      = state;
        word_index_next = word_index;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next      = RD;
                    word_index_next = '0;
                end
            end
            RD:   state_next = WAIT;
            WAIT: state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: state_next = WAIT_TX;
            WAIT_TX: begin
                if (bus.tx_done) begin
                    if (byte_index != 2'd3) begin
                        state_next = SEND;
                    end else if (word_index != LAST_WORD) begin
                        state_next      = RD;
                        word_index_next = word_index + WI_W'(1);
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so each strobe is
    // high for exactly the cycle the FSM spends in the matching state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_addr  <= '0;
            bus.mem_rd_en <= 1'b0;
            bus.tx_data   <= '0;
            bus.tx_start  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            word_index    <= '0;
            byte_index    <= '0;
            shreg         <= '0;
        end else begin
            bus.mem_rd_en <= (state_next == RD);
            bus.tx_start  <= (state_next == SEND);
            done          <= (state_next == FIN);
            busy          <= (state_next != IDLE) && (state_next != FIN);
            word_index    <= word_index_next;
            if (state_next == RD) begin
                bus.mem_addr <= ADDR_W'({word_index_next, 2'b00});
            end
            if (state == LOAD) begin
                shreg       <= bus.mem_rdata;
                bus.tx_data <= bus.mem_rdata[31:24];
                byte_index  <= '0;
            end else if (state == WAIT_TX && bus.tx_done && byte_index != 2'd3) begin
                bus.tx_data <= shreg[23:16];
                shreg       <= {shreg[23:0], 8'h00};
                byte_index  <= byte_index + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_dump_reader.sv
// Scoreboard bench for data_mem_dump_reader: instance A (DEPTH=2) and
// instance B (DEPTH=1), each with a synchronous memory and a UART TX model.
`timescale 1ns/1ps
module tb_data_mem_dump_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a, busy_a, done_a;
    logic start_b, busy_b, done_b;

    data_mem_dump_reader_if #(.ADDR_W(32)) bus_a ();
    data_mem_dump_reader_if #(.ADDR_W(32)) bus_b ();

    data_mem_dump_reader #(.DEPTH(2), .ADDR_W(32)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .busy(busy_a), .done(done_a), .bus(bus_a.master)
    );
    data_mem_dump_reader #(.DEPTH(1), .ADDR_W(32)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .busy(busy_b), .done(done_b), .bus(bus_b.master)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Memories: data appears the cycle after the read strobe and is held.
    logic [31:0] mem_a [2];
    logic [31:0] mem_b;
    always_ff @(posedge clk) if (bus_a.mem_rd_en) bus_a.mem_rdata <= mem_a[bus_a.mem_addr[2]];
    always_ff @(posedge clk) if (bus_b.mem_rd_en) bus_b.mem_rdata <= mem_b;

    // UART TX models: tx_done pulse 3 cycles after tx_start unless hung.
    logic model_done_a = 1'b0, model_done_b = 1'b0;
    logic spur_a, hang_a;
    int unsigned cnt_a = 0, cnt_b = 0;
    assign bus_a.tx_done = model_done_a | spur_a;
    assign bus_b.tx_done = model_done_b;

    initial forever begin
        @(posedge clk); #1;
        model_done_a = 1'b0;
        if (bus_a.tx_start) cnt_a = 3;
        else if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0 && !hang_a) model_done_a = 1'b1;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        model_done_b = 1'b0;
        if (bus_b.tx_start) cnt_b = 3;
        else if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) model_done_b = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected output 0x%08h, nothing expected", name, act);
    endtask

    // Scoreboard queues and monitors.
    logic [31:0] exp_addr_a [$];
    logic [7:0]  exp_byte_a [$];
    logic [31:0] exp_addr_b [$];
    logic [7:0]  exp_byte_b [$];
    int unsigned txs_a = 0, done_cnt_a = 0, txs_b = 0, done_cnt_b = 0;

    always @(negedge clk) begin
        if (bus_a.mem_rd_en) begin
            if (exp_addr_a.size() == 0) flag("A.mem_addr", bus_a.mem_addr);
            else check("A.mem_addr", bus_a.mem_addr, exp_addr_a.pop_front());
        end
        if (bus_a.tx_start) begin
            txs_a++;
            if (exp_byte_a.size() == 0) flag("A.tx_data", {24'h0, bus_a.tx_data});
            else check("A.tx_data", {24'h0, bus_a.tx_data}, {24'h0, exp_byte_a.pop_front()});
        end
        if (done_a) done_cnt_a++;
    end

    always @(negedge clk) begin
        if (bus_b.mem_rd_en) begin
            if (exp_addr_b.size() == 0) flag("B.mem_addr", bus_b.mem_addr);
            else check("B.mem_addr", bus_b.mem_addr, exp_addr_b.pop_front());
        end
        if (bus_b.tx_start) begin
            txs_b++;
            if (exp_byte_b.size() == 0) flag("B.tx_data", {24'h0, bus_b.tx_data});
            else check("B.tx_data", {24'h0, bus_b.tx_data}, {24'h0, exp_byte_b.pop_front()});
        end
        if (done_b) done_cnt_b++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_a(input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0] all;
        all = {w0, w1};
        exp_addr_a.push_back(32'h0);
        exp_addr_a.push_back(32'h4);
        for (int i = 7; i >= 0; i--) exp_byte_a.push_back(all[i*8 +: 8]);
    endtask

    // Wait for a done pulse, then confirm exactly one, idle, and all expectations consumed.
    task automatic finish_run(input bit sel_b, input string name);
        int unsigned base;
        int unsigned n;
        base = sel_b ? done_cnt_b : done_cnt_a;
        n = 0;
        while (((sel_b ? done_cnt_b : done_cnt_a) == base) && n < 400) begin
            tick();
            n++;
        end
        repeat (10) tick();
        check({name, ".done_count"}, (sel_b ? done_cnt_b : done_cnt_a) - base, 32'd1);
        check({name, ".busy_after"}, {31'h0, sel_b ? busy_b : busy_a}, 32'd0);
        check({name, ".left_over"}, sel_b ? exp_addr_b.size() + exp_byte_b.size()
                                          : exp_addr_a.size() + exp_byte_a.size(), 32'd0);
    endtask

    task automatic wait_txs_a(input int unsigned target, input string name);
        int unsigned n;
        n = 0;
        while (txs_a < target && n < 400) begin
            tick();
            n++;
        end
        check({name, ".tx_start_count"}, txs_a, target);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("A.reset_now.tx_start", {31'h0, bus_a.tx_start}, 32'd0);
        check("A.reset_now.busy", {31'h0, busy_a}, 32'd0);
        check("A.reset_now.mem_addr", bus_a.mem_addr, 32'd0);
        tick();
        reset = 1'b0;
        exp_addr_a.delete();
        exp_byte_a.delete();
        repeat (10) tick();
    endtask

    int unsigned base_txs;

    initial begin
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; spur_a = 1'b0; hang_a = 1'b0;
        repeat (3) tick();
        check("A.reset.mem_addr", bus_a.mem_addr, 32'd0);
        check("A.reset.ctrl", {20'h0, bus_a.mem_rd_en, bus_a.tx_data, bus_a.tx_start, busy_a, done_a}, 32'd0);
        check("B.reset.ctrl", {20'h0, bus_b.mem_rd_en, bus_b.tx_data, bus_b.tx_start, busy_b, done_b}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // DEPTH=1: one word, four bytes MSB first.
        mem_b = 32'h11223344;
        exp_addr_b.push_back(32'h0);
        exp_byte_b.push_back(8'h11); exp_byte_b.push_back(8'h22);
        exp_byte_b.push_back(8'h33); exp_byte_b.push_back(8'h44);
        start_b = 1'b1; tick(); start_b = 1'b0;
        check("B.busy_rise", {31'h0, busy_b}, 32'd1);
        finish_run(1'b1, "B.depth1");
        check("B.byte_count", txs_b, 32'd4);

        // DEPTH=2 clean run.
        mem_a[0] = 32'h00000003; mem_a[1] = 32'h00000007;
        push_a(32'h00000003, 32'h00000007);
        start_a = 1'b1; tick(); start_a = 1'b0;
        finish_run(1'b0, "A.clean");

        // start re-pulsed during the second byte is ignored.
        mem_a[0] = 32'h01020304; mem_a[1] = 32'h05060708;
        push_a(32'h01020304, 32'h05060708);
        base_txs = txs_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_txs_a(base_txs + 2, "A.restart");
        start_a = 1'b1; tick(); start_a = 1'b0;
        finish_run(1'b0, "A.restart");

        // Spurious tx_done in RD and in LOAD leave the stream unchanged.
        mem_a[0] = 32'h00000003; mem_a[1] = 32'h00000007;
        push_a(32'h00000003, 32'h00000007);
        start_a = 1'b1; tick(); start_a = 1'b0;
        spur_a = 1'b1; tick();
        spur_a = 1'b0; tick();
        spur_a = 1'b1; tick();
        spur_a = 1'b0;
        finish_run(1'b0, "A.spurious");

        // Reset in WAIT_TX of word 1, byte 2, then a fresh dump from address 0.
        push_a(32'h00000003, 32'h00000007);
        base_txs = txs_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_txs_a(base_txs + 7, "A.midreset");
        tick();
        check("A.midreset.pending", exp_byte_a.size(), 32'd1);
        pulse_reset();
        check("A.midreset.quiet", txs_a, base_txs + 7);
        mem_a[0] = 32'hCAFEF00D; mem_a[1] = 32'h12345678;
        push_a(32'hCAFEF00D, 32'h12345678);
        start_a = 1'b1; tick(); start_a = 1'b0;
        finish_run(1'b0, "A.after_reset");

        // TX never answers: one tx_start, held data, still busy.
        mem_a[0] = 32'hA5B6C7D8;
        exp_addr_a.push_back(32'h0);
        exp_byte_a.push_back(8'hA5);
        hang_a = 1'b1;
        base_txs = txs_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_txs_a(base_txs + 1, "A.hang");
        repeat (40) tick();
        check("A.hang.tx_start_once", txs_a, base_txs + 1);
        check("A.hang.busy", {31'h0, busy_a}, 32'd1);
        check("A.hang.tx_data", {24'h0, bus_a.tx_data}, 32'h000000A5);
        check("A.hang.left_over", exp_addr_a.size() + exp_byte_a.size(), 32'd0);
        pulse_reset();
        hang_a = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
